// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encodings,
// sequential PC increment and the default reset vector.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_HOLD    = 2'd2,
    FS_DISCARD = 2'd3
  } fetch_state_e;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: PC generation, single-outstanding imem handshake,
// one-entry hold buffer under decode stall, and redirect-while-outstanding discard.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  exc_redirect,
  input  logic [DATA_WIDTH-1:0] exc_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] inst_out,
  output logic                  bubble_out
);

  fetch_state_e          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_pend_pc, w_pend_pc_nxt;
  logic [DATA_WIDTH-1:0] r_hold_inst, w_hold_inst_nxt;
  logic                  w_redir;
  logic [DATA_WIDTH-1:0] w_target;

  // Sequential successor; wraps modulo 2^DATA_WIDTH by construction.
  function automatic logic [DATA_WIDTH-1:0] seq_pc(input logic [DATA_WIDTH-1:0] pc);
    return pc + DATA_WIDTH'(PC_INC);
  endfunction

  assign w_redir   = exc_redirect | redirect;
  assign w_target  = exc_redirect ? exc_pc : redirect_pc;
  assign imem_addr = r_pc;

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_pc_nxt   = r_pend_pc;
    w_hold_inst_nxt = r_hold_inst;
    imem_req        = 1'b0;
    bubble_out      = 1'b1;
    pc_out          = '0;
    inst_out        = '0;

    unique case (r_state)
      FS_IDLE: begin
        w_state_nxt = FS_FETCH;
        if (w_redir) w_pc_nxt = w_target;
      end

      FS_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (w_redir) begin
            w_pc_nxt = w_target;
          end else begin
            bubble_out = 1'b0;
            pc_out     = r_pc;
            inst_out   = imem_rdata;
            if (stall) begin
              // Decode is presented the word now but will not take it; keep a copy.
              w_hold_inst_nxt = imem_rdata;
              w_state_nxt     = FS_HOLD;
            end else begin
              w_pc_nxt = seq_pc(r_pc);
            end
          end
        end else if (w_redir) begin
          w_pend_pc_nxt = w_target;
          w_state_nxt   = FS_DISCARD;
        end
      end

      FS_HOLD: begin
        if (w_redir) begin
          w_pc_nxt    = w_target;
          w_state_nxt = FS_FETCH;
        end else begin
          bubble_out = 1'b0;
          pc_out     = r_pc;
          inst_out   = r_hold_inst;
          if (!stall) begin
            w_pc_nxt    = seq_pc(r_pc);
            w_state_nxt = FS_FETCH;
          end
        end
      end

      FS_DISCARD: begin
        // Old request stays on the bus until memory answers; its data is thrown away.
        imem_req = 1'b1;
        if (w_redir) w_pend_pc_nxt = w_target;
        if (imem_ack) begin
          w_pc_nxt    = w_redir ? w_target : r_pend_pc;
          w_state_nxt = FS_FETCH;
        end
      end

      default: w_state_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FS_IDLE;
      r_pc        <= RESET_PC;
      r_hold_inst <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_hold_inst <= w_hold_inst_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_pend_pc <= w_pend_pc_nxt;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit; instruction memory returns ~address as the word.
module tb_inst_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc_redirect;
  logic [31:0] exc_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        bubble_out;

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc_redirect(exc_redirect),
    .exc_pc      (exc_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .bubble_out  (bubble_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic ex, input logic [31:0] epc, input logic ack);
    stall        = st;
    redirect     = rd;
    redirect_pc  = rpc;
    exc_redirect = ex;
    exc_pc       = epc;
    imem_ack     = ack;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    check("rst_req",    imem_req,   0);
    check("rst_addr",   imem_addr,  32'h0);
    check("rst_bubble", bubble_out, 1);
    check("rst_pc",     pc_out,     32'h0);
    check("rst_inst",   inst_out,   32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("idle_req",    imem_req,   0);
    check("idle_bubble", bubble_out, 1);

    // Streaming, ack every cycle
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("s0_addr", imem_addr, 32'h0);
    check("s0_req",  imem_req,  1);
    check("s0_bub",  bubble_out, 0);
    check("s0_inst", inst_out,  32'hFFFF_FFFF);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("s1_addr", imem_addr, 32'h4);
    check("s1_inst", inst_out,  32'hFFFF_FFFB);
    check("s1_pc",   pc_out,    32'h4);

    // Stall at address 8 for three cycles
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("st8_addr", imem_addr, 32'h8);
    check("st8_bub",  bubble_out, 0);
    check("st8_inst", inst_out,  32'hFFFF_FFF7);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("hold1_req",  imem_req,  0);
    check("hold1_bub",  bubble_out, 0);
    check("hold1_inst", inst_out,  32'hFFFF_FFF7);
    check("hold1_pc",   pc_out,    32'h8);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("hold2_inst", inst_out, 32'hFFFF_FFF7);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("hold3_bub",  bubble_out, 0);
    check("hold3_inst", inst_out,  32'hFFFF_FFF7);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("after_hold_addr", imem_addr, 32'hC);
    check("after_hold_inst", inst_out,  32'hFFFF_FFF3);

    // Delayed ack with redirect while outstanding
    tick(); drive(0, 1, 32'h100, 0, 0, 0);
    check("dly0_addr", imem_addr, 32'h10);
    check("dly0_bub",  bubble_out, 1);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("dly1_addr", imem_addr, 32'h10);
    check("dly1_req",  imem_req,  1);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("dly2_addr", imem_addr, 32'h10);
    check("dly2_bub",  bubble_out, 1);
    check("dly2_inst", inst_out,  32'h0);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_bub",  bubble_out, 0);
    check("redir_inst", inst_out,  32'hFFFF_FEFF);

    // Newest redirect wins while discarding
    tick(); drive(0, 1, 32'h200, 0, 0, 0);
    check("dsc0_addr", imem_addr, 32'h104);
    tick(); drive(0, 0, 0, 1, 32'h180, 0);
    check("dsc1_addr", imem_addr, 32'h104);
    check("dsc1_bub",  bubble_out, 1);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("dsc2_addr", imem_addr, 32'h104);
    check("dsc2_bub",  bubble_out, 1);
    tick(); drive(0, 1, 32'h300, 1, 32'h380, 1);
    check("exc_addr",   imem_addr, 32'h180);
    check("both_bub",   bubble_out, 1);
    tick(); drive(1, 0, 0, 0, 0, 1);
    check("both_addr",  imem_addr, 32'h380);
    check("both_inst",  inst_out,  32'hFFFF_FC7F);

    // Redirect during hold
    tick(); drive(1, 1, 32'h400, 0, 0, 1);
    check("hredir_req",  imem_req,  0);
    check("hredir_bub",  bubble_out, 1);
    check("hredir_inst", inst_out,  32'h0);
    check("hredir_pc",   pc_out,    32'h0);
    tick(); drive(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    check("hredir_addr", imem_addr, 32'h400);
    check("hredir_bub2", bubble_out, 1);

    // PC wrap
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_pc",   pc_out,    32'hFFFF_FFFC);
    check("wrap_inst", inst_out,  32'h0000_0003);
    tick(); drive(0, 0, 0, 0, 0, 1);
    check("wrap_next", imem_addr, 32'h0);
    check("wrap_ninst", inst_out, 32'hFFFF_FFFF);

    // Reset asserted in the middle of DISCARD
    tick(); drive(0, 1, 32'h500, 0, 0, 0);
    check("prd_addr", imem_addr, 32'h4);
    tick(); drive(0, 0, 0, 0, 0, 0);
    check("md_req",  imem_req,  1);
    check("md_addr", imem_addr, 32'h4);
    rst_n = 1'b0;
    #1;
    check("mrst_req",  imem_req,   0);
    check("mrst_addr", imem_addr,  32'h0);
    check("mrst_bub",  bubble_out, 1);
    @(negedge clk);
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    tick(); #2;
    check("post_req",  imem_req,  1);
    check("post_addr", imem_addr, 32'h0);
    check("post_bub",  bubble_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
